// File: rtl/am_similarity_accumulator_pkg.sv
// Shared HDC package (hdc_pkg) for the associative-memory similarity path.
// Holds the fixed sizing constants, the similarity word type, the per-chunk
// popcount type and the accumulator FSM state encoding.
package hdc_pkg;
  localparam int NUM_CLASSES = 26;
  localparam int HV_DIM      = 5120;
  localparam int CHUNK_W     = 64;
  localparam int SIM_W       = 13;
  localparam int CLASS_IDX_W = 5;
  localparam int NUM_CHUNKS  = HV_DIM / CHUNK_W;
  localparam int CHUNK_IDX_W = $clog2(NUM_CHUNKS);
  localparam int POP_W       = $clog2(CHUNK_W + 1);

  typedef logic [SIM_W-1:0] sim_t;
  typedef logic [POP_W-1:0] pop_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/am_similarity_accumulator_if.sv
// Query-stream and class-memory read bus of the similarity accumulator.
//   q_valid / q_ready / q_data       : query chunk stream (chunk 0 first)
//   am_rd_en / am_rd_addr            : class-memory read strobe and chunk index
//   am_rd_data                       : all class chunks, class c at [c*CHUNK_W +: CHUNK_W],
//                                      returned one cycle after the read strobe
// slave  : the accumulator side; master : query source plus class memory.
interface am_similarity_accumulator_if import hdc_pkg::*; ();
  logic                           q_valid;
  logic                           q_ready;
  logic [CHUNK_W-1:0]             q_data;
  logic                           am_rd_en;
  logic [CHUNK_IDX_W-1:0]         am_rd_addr;
  logic [NUM_CLASSES*CHUNK_W-1:0] am_rd_data;

  modport slave (
    input  q_valid, q_data, am_rd_data,
    output q_ready, am_rd_en, am_rd_addr
  );

  modport master (
    output q_valid, q_data, am_rd_data,
    input  q_ready, am_rd_en, am_rd_addr
  );
endinterface

// File: rtl/am_similarity_accumulator_popcount.sv
// chunk_overlap_popcount: purely combinational overlap count of one query
// chunk against one class chunk.
//   i_query : query chunk
//   i_class : class chunk at the same index
//   o_count : popcount(i_query & i_class)
module chunk_overlap_popcount import hdc_pkg::*; (
  input  logic [CHUNK_W-1:0] i_query,
  input  logic [CHUNK_W-1:0] i_class,
  output pop_t               o_count
);
  logic [CHUNK_W-1:0] w_and;

  assign w_and = i_query & i_class;

  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      o_count = o_count + pop_t'(w_and[i]);
    end
  end
endmodule

// File: rtl/am_similarity_accumulator.sv
// am_similarity_accumulator: streams one query hypervector chunk by chunk,
// reads the matching chunk of every class HV and accumulates the per-class
// overlap popcount. Feeds the AM tree comparator.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a new query (honoured only when idle)
//   bus         : query stream + class-memory read port (slave side)
//   busy        : FSM not idle
//   sim_valid   : one-cycle pulse, sim_values final while high
//   sim_values  : per-class similarity, held until the next query clears them
module am_similarity_accumulator import hdc_pkg::*; (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  am_similarity_accumulator_if.slave   bus,
  output logic                         busy,
  output logic                         sim_valid,
  output sim_t [0:NUM_CLASSES-1]       sim_values
);
  if (((HV_DIM % CHUNK_W) != 0) || (HV_DIM >= (1 << SIM_W))) begin : g_param_check
    $error("HV_DIM must be a multiple of CHUNK_W and fit in SIM_W bits");
  end

  state_t                  r_state;
  logic [CHUNK_IDX_W-1:0]  r_chunk_idx;
  logic                    r_q_ready;
  logic                    r_busy;
  logic                    r_sim_valid;
  logic                    r_stage_valid;
  logic [CHUNK_W-1:0]      r_stage_q;
  sim_t [0:NUM_CLASSES-1]  r_sim;

  pop_t                    w_pop [NUM_CLASSES];
  logic                    w_accept;

  // Gating with rst keeps the handshake outputs at 0 for the whole reset
  // cycle, not only after the first reset edge.
  assign w_accept       = bus.q_valid && r_q_ready && !rst;
  assign bus.q_ready    = r_q_ready && !rst;
  assign bus.am_rd_en   = w_accept;
  assign bus.am_rd_addr = w_accept ? r_chunk_idx : '0;

  assign busy       = r_busy;
  assign sim_valid  = r_sim_valid;
  assign sim_values = r_sim;

  // Memory data for a chunk returns one cycle after its accept, aligned with
  // the staged query chunk, so the popcounts pair r_stage_q with am_rd_data.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_pop
    chunk_overlap_popcount u_pop (
      .i_query (r_stage_q),
      .i_class (bus.am_rd_data[gi*CHUNK_W +: CHUNK_W]),
      .o_count (w_pop[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_chunk_idx   <= '0;
      r_q_ready     <= 1'b0;
      r_busy        <= 1'b0;
      r_sim_valid   <= 1'b0;
      r_stage_valid <= 1'b0;
      r_stage_q     <= '0;
      r_sim         <= '0;
    end else begin
      r_sim_valid <= 1'b0;

      if (r_stage_valid) begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          r_sim[c] <= r_sim[c] + {{(SIM_W-POP_W){1'b0}}, w_pop[c]};
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sim       <= '0;
            r_chunk_idx <= '0;
            r_q_ready   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          r_stage_valid <= w_accept;
          if (w_accept) begin
            r_stage_q   <= bus.q_data;
            r_chunk_idx <= r_chunk_idx + 1'b1;
            if (r_chunk_idx == CHUNK_IDX_W'(NUM_CHUNKS - 1)) begin
              r_q_ready <= 1'b0;
              r_state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // last staged chunk accumulates on this edge
          r_stage_valid <= 1'b0;
          r_sim_valid   <= 1'b1;
          r_state       <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_am_similarity_accumulator.sv
module tb_am_similarity_accumulator;
  import hdc_pkg::*;

  typedef sim_t [0:NUM_CLASSES-1] simvec_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    start = 1'b0;
  logic    busy;
  logic    sim_valid;
  simvec_t sim_values;

  am_similarity_accumulator_if bus();

  am_similarity_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .sim_valid  (sim_valid),
    .sim_values (sim_values)
  );

  always #5 clk = ~clk;

  // class memory and query image
  logic [NUM_CLASSES*CHUNK_W-1:0] mem [NUM_CHUNKS];
  logic [CHUNK_W-1:0]             qv  [NUM_CHUNKS];

  always @(posedge clk) begin
    if (bus.am_rd_en) bus.am_rd_data <= mem[bus.am_rd_addr];
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rd_count = 0;
  logic prev_sv = 1'b0;
  simvec_t exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference: similarity = total overlap of the query with each class HV
  function automatic simvec_t model();
    simvec_t r;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      int s = 0;
      for (int i = 0; i < NUM_CHUNKS; i++) s += $countones(qv[i] & mem[i][c*CHUNK_W +: CHUNK_W]);
      r[c] = sim_t'(s);
    end
    return r;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      rd_count = 0;
      prev_sv  = 1'b0;
    end else begin
      if (bus.am_rd_en) begin
        chk("rd_addr_order", 512'(bus.am_rd_addr), 512'(rd_count));
        rd_count++;
      end
      if (sim_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_sim_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("sim_values", 512'(sim_values), 512'(exp_q.pop_front()));
        end
        chk("rd_en_count", 512'(rd_count), 512'(NUM_CHUNKS));
        chk("valid_latency", 512'(cyc - acc_cyc), 512'(2));
        chk("valid_single_pulse", 512'(prev_sv), 512'(0));
        $display("query done at cycle %0d: sim[0]=%0d sim[25]=%0d", cyc, sim_values[0], sim_values[25]);
        rd_count = 0;
      end
      prev_sv = sim_valid;
    end
  end

  task automatic load_graded();
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      qv[i] = '1;
      for (int k = 0; k < NUM_CLASSES; k++)
        mem[i][k*CHUNK_W +: CHUNK_W] = (k == 0) ? 64'd0 : ((64'd1 << k) - 64'd1);
    end
  endtask

  task automatic load_maxzero();
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      qv[i] = '1;
      for (int k = 0; k < NUM_CLASSES; k++)
        mem[i][k*CHUNK_W +: CHUNK_W] = {$urandom(), $urandom()};
      mem[i][0 +: CHUNK_W]       = '1;
      mem[i][CHUNK_W +: CHUNK_W] = '0;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      qv[i] = {$urandom(), $urandom()};
      for (int k = 0; k < NUM_CLASSES; k++)
        mem[i][k*CHUNK_W +: CHUNK_W] = {$urandom(), $urandom()};
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("q_ready_after_start", 512'(bus.q_ready), 512'(1));
    chk("busy_after_start", 512'(busy), 512'(1));
  endtask

  // stream the first n_send chunks; optional start pulse alongside chunk start_at
  task automatic stream(input int gap_pct, input int start_at, input int n_send);
    for (int i = 0; i < n_send; i++) begin
      int   budget = 0;
      logic acc;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.q_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.q_valid = 1'b1;
      bus.q_data  = qv[i];
      if (i == start_at) start = 1'b1;
      forever begin
        @(negedge clk);
        acc = bus.q_ready;
        if (acc) acc_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (acc) break;
        budget++;
        if (budget > 20) begin
          n_cmp++; n_fail++;
          $display("FAIL accept_timeout: got q_ready=0 expected 1 (chunk %0d)", i);
          bus.q_valid = 1'b0;
          return;
        end
      end
    end
    bus.q_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < 300) begin
      @(posedge clk); #1; budget++;
    end
    chk("result_pending", 512'(exp_q.size()), 512'(0));
  endtask

  task automatic run_query(input int gap_pct, input int start_at);
    do_start();
    exp_q.push_back(model());
    stream(gap_pct, start_at, NUM_CHUNKS);
    wait_idle();
  endtask

  initial begin
    simvec_t exp1;
    int      budget;
    bus.q_valid = 1'b0;
    bus.q_data  = '0;

    // 1: reset, then q_valid without start must not be accepted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 512'({busy, sim_valid, bus.q_ready, bus.am_rd_en, bus.am_rd_addr}), 512'(0));
    chk("reset_sim_values", 512'(sim_values), 512'(0));
    @(posedge clk); #1 rst = 1'b0;
    bus.q_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("q_ready_no_start", 512'({bus.q_ready, bus.am_rd_en}), 512'(0));
    end
    @(posedge clk); #1 bus.q_valid = 1'b0;

    // 2: graded classes, no gaps
    load_graded();
    run_query(0, -1);
    // 3: maximum and zero overlap
    load_maxzero();
    run_query(0, -1);
    // 4: graded data with random back-pressure
    load_graded();
    run_query(40, -1);
    // 5a: start pulsed mid-stream is ignored
    load_random();
    run_query(20, 20);

    // 5b: reset after 40 chunks, then a fresh query
    load_graded();
    do_start();
    stream(0, -1, 40);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_handshake", 512'({bus.q_ready, bus.am_rd_en}), 512'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_midstream_outputs", 512'({busy, sim_valid, bus.q_ready, bus.am_rd_en}), 512'(0));
    chk("rst_midstream_sim", 512'(sim_values), 512'(0));
    @(posedge clk); #1 rst = 1'b0;
    load_random();
    run_query(30, -1);

    // 6: back-to-back queries, second start in T+3
    load_random();
    do_start();
    exp1 = model();
    exp_q.push_back(exp1);
    stream(0, -1, NUM_CHUNKS);
    budget = 0;
    do begin
      @(negedge clk); budget++;
    end while (!sim_valid && budget < 10);
    chk("b2b_sim_valid_seen", 512'(sim_valid), 512'(1));
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    chk("b2b_hold_T3", 512'(sim_values), 512'(exp1));
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_clear_T4", 512'(sim_values), 512'(0));
    @(posedge clk); #1;
    load_graded();
    exp_q.push_back(model());
    stream(10, -1, NUM_CHUNKS);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
